// File: rtl/carry_lookahead_adder_if.sv
// Operand/result bundle for the Kogge-Stone adder.
// The master drives the operands; the slave (adder) drives every result.
`timescale 1ns/1ps
interface carry_lookahead_adder_if #(
    parameter int WIDTH = 8
);
    logic             carry_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    modport master (
        output carry_in, a, b,
        input  sum, carry_out, sum_q, carry_q
    );

    modport slave (
        input  carry_in, a, b,
        output sum, carry_out, sum_q, carry_q
    );
endinterface

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit Kogge-Stone parallel-prefix adder with combinational result
// and a one-cycle registered copy (async active-low reset on the copy only).
`timescale 1ns/1ps
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    carry_lookahead_adder_if.slave  bus
);
    // Element 0 carries carry_in as a generate at bit position -1;
    // element j (j >= 1) is operand bit j-1.
    localparam int N      = WIDTH + 1;
    localparam int LEVELS = $clog2(N);

    logic [N-1:0]     w_g [0:LEVELS];
    logic [N-1:0]     w_p [0:LEVELS-1];
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_out;
    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;

    assign w_g[0][0] = bus.carry_in;
    assign w_p[0][0] = 1'b0;

    genvar gi, gk;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_g[0][gi+1] = bus.a[gi] & bus.b[gi];
            assign w_p[0][gi+1] = bus.a[gi] ^ bus.b[gi];
        end

        // Group propagate is only needed by the levels that still follow.
        for (gk = 0; gk < LEVELS; gk++) begin : g_level
            for (gi = 0; gi < N; gi++) begin : g_node
                if (gi >= (2 ** gk)) begin : g_combine
                    assign w_g[gk+1][gi] = w_g[gk][gi]
                                         | (w_p[gk][gi] & w_g[gk][gi-(2**gk)]);
                    if (gk < LEVELS - 1) begin : g_prop
                        assign w_p[gk+1][gi] = w_p[gk][gi] & w_p[gk][gi-(2**gk)];
                    end
                end else begin : g_pass
                    assign w_g[gk+1][gi] = w_g[gk][gi];
                    if (gk < LEVELS - 1) begin : g_prop
                        assign w_p[gk+1][gi] = w_p[gk][gi];
                    end
                end
            end
        end

        for (gi = 0; gi < WIDTH; gi++) begin : g_sum
            assign w_sum[gi] = w_p[0][gi+1] ^ w_g[LEVELS][gi];
        end
    endgenerate

    assign w_carry_out = w_g[LEVELS][WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
        end else begin
            r_sum_q   <= w_sum;
            r_carry_q <= w_carry_out;
        end
    end

    assign bus.sum       = w_sum;
    assign bus.carry_out = w_carry_out;
    assign bus.sum_q     = r_sum_q;
    assign bus.carry_q   = r_carry_q;
endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Scoreboarded bench: exhaustive 8-bit combinational sweep, registered path
// with reset cases, and random width sweep at 1/5/16/32 bits.
`timescale 1ns/1ps
module tb_carry_lookahead_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    carry_lookahead_adder_if #(.WIDTH(8)) bus ();
    carry_lookahead_adder #(.WIDTH(8)) kogge_stone_adder_inst (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int sweep_cnt = 0;
    logic [8:0] exp_q [$];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] req;
    } vec_t;

    vec_t dir_vec [7] = '{
        '{8'hFF, 8'h01, 1'b0, 9'h100},
        '{8'hFF, 8'h00, 1'b1, 9'h100},
        '{8'h7F, 8'h01, 1'b0, 9'h080},
        '{8'h00, 8'h00, 1'b0, 9'h000},
        '{8'hFF, 8'hFF, 1'b1, 9'h1FF},
        '{8'hAA, 8'h55, 1'b1, 9'h100},
        '{8'h10, 8'h20, 1'b1, 9'h031}
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[8:0];
    endfunction

    // Applies operands, checks the combinational result, optionally queues it for the register.
    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic c, input bit push);
        logic [8:0] e;
        bus.a = x;
        bus.b = y;
        bus.carry_in = c;
        #1;
        e = ref8(x, y, c);
        check("comb_sum", 64'(bus.sum), 64'(e[7:0]));
        check("comb_carry", 64'(bus.carry_out), 64'(e[8]));
        if (push) exp_q.push_back(e);
    endtask

    // Monitor: each registered capture retires one queued expectation.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("reg_sum", 64'(bus.sum_q), 64'(e[7:0]));
            check("reg_carry", 64'(bus.carry_q), 64'(e[8]));
            $display("txn a=%02h b=%02h cin=%0d -> sum_q=%02h carry_q=%0d",
                     bus.a, bus.b, bus.carry_in, bus.sum_q, bus.carry_q);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sweep
            localparam int W = (gi == 0) ? 1 : (gi == 1) ? 5 : (gi == 2) ? 16 : 32;
            carry_lookahead_adder_if #(.WIDTH(W)) sbus ();
            carry_lookahead_adder #(.WIDTH(W)) dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (sbus)
            );
            initial begin
                logic [W-1:0] x, y;
                logic c;
                longint unsigned tot, mask;
                mask = (W == 64) ? '1 : ((64'd1 << W) - 64'd1);
                for (int n = 0; n < 10000; n++) begin
                    x = W'($urandom);
                    y = W'($urandom);
                    c = 1'($urandom);
                    if (n % 16 == 0) x = '1;
                    if (n % 32 == 0) y = '1;
                    sbus.a = x;
                    sbus.b = y;
                    sbus.carry_in = c;
                    #1;
                    tot = longint'(x) + longint'(y) + longint'(c);
                    check($sformatf("sweep_sum_w%0d", W), 64'(sbus.sum), tot & mask);
                    check($sformatf("sweep_carry_w%0d", W), 64'(sbus.carry_out), (tot >> W) & 64'd1);
                end
                sweep_cnt++;
            end
        end
    endgenerate

    initial begin
        logic [8:0] e;
        bus.a = '0;
        bus.b = '0;
        bus.carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum_q", 64'(bus.sum_q), 64'd0);
        check("rst_carry_q", 64'(bus.carry_q), 64'd0);

        // Combinational path while reset is held low.
        foreach (dir_vec[i]) begin
            drive(dir_vec[i].a, dir_vec[i].b, dir_vec[i].c, 1'b0);
            e = dir_vec[i].req;
            check("dir_sum", 64'(bus.sum), 64'(e[7:0]));
            check("dir_carry", 64'(bus.carry_out), 64'(e[8]));
        end
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 256; y++)
                for (int c = 0; c < 2; c++)
                    drive(8'(x), 8'(y), 1'(c), 1'b0);
        check("rst_hold_sum_q", 64'(bus.sum_q), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(8'h10, 8'h20, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        check("reg_31_sum_q", 64'(bus.sum_q), 64'h31);
        check("reg_31_carry_q", 64'(bus.carry_q), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum_q", 64'(bus.sum_q), 64'd0);
        check("async_rst_carry_q", 64'(bus.carry_q), 64'd0);
        check("async_rst_comb", 64'(bus.sum), 64'h31);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset lands while a result is in flight: it must be dropped.
        @(negedge clk);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_sum_q", 64'(bus.sum_q), 64'd0);
        check("midrst_carry_q", 64'(bus.carry_q), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_hold_sum_q", 64'(bus.sum_q), 64'd0);
        check("midrst_hold_carry_q", 64'(bus.carry_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        repeat (4) @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        for (int t = 0; t < 2000 && sweep_cnt < 4; t++) @(posedge clk);
        check("sweep_done", 64'(sweep_cnt), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
